av2_recon_frame_store: RTL and testbench
========================================

// Module: av2_recon_frame_store
// PURPOSE
//  Receiving end of the tile decoder's recon write port and responding end of its reference read port.
//  Accepts 128-bit beats (16 pixels each) and unpacks them into a ping-pong pair of frame banks.
//  On tile_done the filled bank becomes the front bank.
//  Pixel reads from the front bank have 1-cycle latency; they feed the next frame's reference fetches.
// PARAMETERS
//  MAX_WIDTH    128  max luma width in pixels
//  MAX_HEIGHT   128  max luma height in pixels
//  PIXEL_WIDTH  10   stored/returned pixel width
//  LANE_WIDTH   8    pixel lane width inside recon_data (16 lanes x 8 = 128)
//  UNAVAIL_PIX  128  value returned for unavailable/out-of-range reads
// PORTS
//  clk             in   1    clock
//  rst             in   1    asynchronous reset, active-high
//  frame_width     in   16   width in pixels, latched on IDLE->FILL
//  frame_height    in   16   height in pixels, latched on IDLE->FILL
//  recon_data      in   128  lane k = recon_data[8k+7:8k] = pixel recon_addr+k
//  recon_addr      in   32   linear pixel index of lane 0, multiple of 16
//  recon_wr_en     in   1    beat valid; no backpressure, every asserted cycle is a beat
//  tile_done       in   1    1-cycle pulse: frame complete, swap banks
//  ref_read_en     in   1    read request
//  ref_read_addr   in   32   linear pixel index y*width+x
//  ref_pixel_data  out  PIXEL_WIDTH  read data, valid with ref_rd_valid
//  ref_rd_valid    out  1    asserted exactly 1 cycle after each ref_read_en
//  frame_ready     out  1    1-cycle pulse on bank swap
//  front_valid     out  1    front bank holds a complete frame
//  frame_beats     out  16   unique beats in last swapped frame
//  addr_err        out  1    sticky: misaligned or out-of-range beat dropped; cleared on IDLE->FILL
// BEHAVIOUR
//  Reset values: all outputs 0; back bank select = 0; last_addr invalid. Bank memory is not cleared.
//  Reset mid-fill: the partial frame is abandoned and front_valid = 0.
//  State machine:
//   IDLE -> FILL on the first recon_wr_en. Latches dims, total = w*h, beat counter = 0, clears addr_err.
//    The triggering beat is processed normally in that same cycle.
//   FILL -> IDLE on tile_done. Back bank becomes front and the back select toggles.
//    Also: front dims <= latched dims, frame_beats <= count, front_valid <= 1, frame_ready = 1 next cycle.
//   tile_done in IDLE is ignored: no swap, no pulse.
//  Write rules, per beat:
//   - recon_addr[3:0] != 0, or recon_addr >= total, or recon_addr >= MAX_WIDTH*MAX_HEIGHT:
//     drop the whole beat and set addr_err.
//   - Otherwise lane k goes to back[addr+k] when addr+k < total; lanes beyond total are discarded.
//   - Each lane is zero-extended from LANE_WIDTH to PIXEL_WIDTH.
//   - Beat counter increments only if addr != last accepted addr.
//     A repeated beat (writer holding wr_en on its final cycle) rewrites identically and is not counted.
//   - The counter saturates at 16'hFFFF.
//  Read rules: registered, fixed 1-cycle latency, one read per cycle, back-to-back supported.
//   - Returns UNAVAIL_PIX when front_valid = 0, or addr >= front w*h, or addr >= MAX_WIDTH*MAX_HEIGHT.
//   - ref_pixel_data holds its value when ref_rd_valid = 0.
//  Simultaneous events:
//   - recon_wr_en with tile_done: the beat is written to the back bank first, then that bank swaps to front.
//   - ref_read_en with tile_done: served from the pre-swap front bank.
//   - Reads never observe back-bank writes.
// TESTING
//  1. 32x32 frame: 64 beats at addr 0,16..1008, every lane = beat idx; tile_done.
//     -> frame_ready 1 cycle, frame_beats=64, front_valid=1; read addr 17 -> 10'd1 one cycle later.
//  2. Same frame with the addr 1008 beat repeated 3 cycles -> frame_beats=64, addr_err=0, read 1008 -> 10'd63.
//  3. Read addr 0 after reset, before any frame -> ref_rd_valid next cycle, data=128.
//     Read addr 1024 on a 32x32 front -> 128.
//  4. Beat at addr 8 -> addr_err=1, nothing written.
//     Beat at addr 1024 on 32x32 -> addr_err=1. Next frame's first beat -> addr_err=0.
//  5. Ping-pong: frame A lanes=5 swapped in; fill frame B lanes=9 while reading addr 0 -> 5.
//     tile_done with a same-cycle read -> 5; the following read -> 9.
//  6. rst pulse after 10 beats of a fill -> outputs 0 and front_valid=0.
//     A read returns 128; tile_done in IDLE gives no frame_ready.

Source files
------------

// File: rtl/av2_recon_frame_store.sv
// Ping-pong recon frame store: unpacks 16-pixel recon beats into the back bank, serves pixel reads from the front bank.
// Latency: reads return exactly 1 cycle after ref_read_en; bank swap visible the cycle after tile_done.
// Backpressure: none; every recon_wr_en cycle is a beat and every ref_read_en is served.
module av2_recon_frame_store #(
    parameter int MAX_WIDTH   = 128,
    parameter int MAX_HEIGHT  = 128,
    parameter int PIXEL_WIDTH = 10,
    parameter int LANE_WIDTH  = 8,
    parameter int UNAVAIL_PIX = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            frame_width,
    input  logic [15:0]            frame_height,
    input  logic [127:0]           recon_data,
    input  logic [31:0]            recon_addr,
    input  logic                   recon_wr_en,
    input  logic                   tile_done,
    input  logic                   ref_read_en,
    input  logic [31:0]            ref_read_addr,
    output logic [PIXEL_WIDTH-1:0] ref_pixel_data,
    output logic                   ref_rd_valid,
    output logic                   frame_ready,
    output logic                   front_valid,
    output logic [15:0]            frame_beats,
    output logic                   addr_err
);

    localparam int LANES = 16;
    localparam int DEPTH = MAX_WIDTH * MAX_HEIGHT;
    localparam int WORDS = DEPTH / LANES;
    localparam int AW    = $clog2(WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_nxt;

    logic [PIXEL_WIDTH*LANES-1:0] bank0 [WORDS];
    logic [PIXEL_WIDTH*LANES-1:0] bank1 [WORDS];

    logic             back_sel;
    logic [31:0]      total_q, front_total, total_eff, last_addr;
    logic             last_vld;
    logic [15:0]      beat_cnt, cnt_base, cnt_nxt;
    logic             start, swap, beat_bad, beat_ok, repeat_beat, rd_ok;
    logic [LANES-1:0] lane_en;
    logic [AW-1:0]    wr_word, rd_word;
    logic [3:0]       rd_lane;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        swap      = 1'b0;
        case (state)
            IDLE: if (recon_wr_en) begin
                state_nxt = FILL;
                start     = 1'b1;
            end
            FILL: if (tile_done) begin
                state_nxt = IDLE;
                swap      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The beat that opens a frame is checked against the dims being latched in the same cycle.
    assign total_eff   = start ? ({16'd0, frame_width} * {16'd0, frame_height}) : total_q;
    assign beat_bad    = recon_wr_en && (recon_addr[3:0] != 4'd0 || recon_addr >= total_eff
                                         || recon_addr >= DEPTH_L);
    assign beat_ok     = recon_wr_en && !beat_bad;
    assign repeat_beat = (state == FILL) && last_vld && (recon_addr == last_addr);
    assign cnt_base    = start ? 16'd0 : beat_cnt;
    assign cnt_nxt     = (beat_ok && !repeat_beat && cnt_base != 16'hFFFF) ? cnt_base + 16'd1 : cnt_base;
    assign wr_word     = recon_addr[AW+3:4];
    assign rd_word     = ref_read_addr[AW+3:4];
    assign rd_lane     = ref_read_addr[3:0];
    assign rd_ok       = front_valid && (ref_read_addr < front_total) && (ref_read_addr < DEPTH_L);

    always_comb begin
        lane_en = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_en[k] = beat_ok && ((recon_addr + 32'(k)) < total_eff);
        end
    end

    // Bank contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (lane_en[k]) begin
                if (back_sel)
                    bank1[wr_word][k*PIXEL_WIDTH +: PIXEL_WIDTH] <= PIXEL_WIDTH'(recon_data[k*LANE_WIDTH +: LANE_WIDTH]);
                else
                    bank0[wr_word][k*PIXEL_WIDTH +: PIXEL_WIDTH] <= PIXEL_WIDTH'(recon_data[k*LANE_WIDTH +: LANE_WIDTH]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            back_sel       <= 1'b0;
            total_q        <= '0;
            front_total    <= '0;
            beat_cnt       <= '0;
            last_addr      <= '0;
            last_vld       <= 1'b0;
            frame_ready    <= 1'b0;
            front_valid    <= 1'b0;
            frame_beats    <= '0;
            addr_err       <= 1'b0;
            ref_rd_valid   <= 1'b0;
            ref_pixel_data <= '0;
        end else begin
            state        <= state_nxt;
            frame_ready  <= swap;
            ref_rd_valid <= ref_read_en;
            beat_cnt     <= cnt_nxt;
            addr_err     <= (start ? 1'b0 : addr_err) | beat_bad;
            if (start)
                total_q <= total_eff;
            if (beat_ok) begin
                last_addr <= recon_addr;
                last_vld  <= 1'b1;
            end else if (start) begin
                last_vld  <= 1'b0;
            end
            if (swap) begin
                back_sel    <= ~back_sel;
                front_total <= total_eff;
                frame_beats <= cnt_nxt;
                front_valid <= 1'b1;
            end
            // Front bank is the one not selected for writing, so same-cycle swaps read the old front.
            if (ref_read_en) begin
                if (!rd_ok)
                    ref_pixel_data <= PIXEL_WIDTH'(UNAVAIL_PIX);
                else if (back_sel)
                    ref_pixel_data <= bank0[rd_word][rd_lane*PIXEL_WIDTH +: PIXEL_WIDTH];
                else
                    ref_pixel_data <= bank1[rd_word][rd_lane*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_av2_recon_frame_store.sv
// Bench for av2_recon_frame_store: directed frames checked against a pixel-array model every cycle.
module tb_av2_recon_frame_store;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  frame_width = 16'd32;
    logic [15:0]  frame_height = 16'd32;
    logic [127:0] recon_data = '0;
    logic [31:0]  recon_addr = '0;
    logic         recon_wr_en = 1'b0;
    logic         tile_done = 1'b0;
    logic         ref_read_en = 1'b0;
    logic [31:0]  ref_read_addr = '0;
    logic [9:0]   ref_pixel_data;
    logic         ref_rd_valid;
    logic         frame_ready;
    logic         front_valid;
    logic [15:0]  frame_beats;
    logic         addr_err;

    always #5 clk = ~clk;

    av2_recon_frame_store dut (
        .clk            (clk),
        .rst            (rst),
        .frame_width    (frame_width),
        .frame_height   (frame_height),
        .recon_data     (recon_data),
        .recon_addr     (recon_addr),
        .recon_wr_en    (recon_wr_en),
        .tile_done      (tile_done),
        .ref_read_en    (ref_read_en),
        .ref_read_addr  (ref_read_addr),
        .ref_pixel_data (ref_pixel_data),
        .ref_rd_valid   (ref_rd_valid),
        .frame_ready    (frame_ready),
        .front_valid    (front_valid),
        .frame_beats    (frame_beats),
        .addr_err       (addr_err)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: two pixel banks as plain arrays, -1 marks a pixel never written.
    int     m_bank [2][16384];
    int     m_back = 0;
    bit     m_fill = 1'b0, m_fv = 1'b0, m_ready = 1'b0, m_rd_vld = 1'b0, m_err = 1'b0;
    longint m_tot = 0, m_ftot = 0, m_last = -1;
    int     m_cnt = 0, m_beats = 0, m_rd_dat = 0;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16384; i++)
                m_bank[b][i] = -1;
    end

    always @(posedge clk or posedge rst) begin : model
        longint a;
        bit     was_fill;
        if (rst) begin
            m_back = 0; m_fill = 0; m_fv = 0; m_ready = 0; m_rd_vld = 0; m_err = 0;
            m_tot = 0; m_ftot = 0; m_last = -1; m_cnt = 0; m_beats = 0; m_rd_dat = 0;
        end else begin
            was_fill = m_fill;
            m_rd_vld = ref_read_en;
            if (ref_read_en) begin
                a = longint'(ref_read_addr);
                if (m_fv && a < m_ftot && a < 16384)
                    m_rd_dat = m_bank[1 - m_back][int'(a)];
                else
                    m_rd_dat = 128;
            end
            m_ready = 1'b0;
            if (recon_wr_en) begin
                if (!m_fill) begin
                    m_fill = 1'b1;
                    m_tot  = longint'(frame_width) * longint'(frame_height);
                    m_cnt  = 0;
                    m_err  = 1'b0;
                    m_last = -1;
                end
                a = longint'(recon_addr);
                if (a % 16 != 0 || a >= m_tot || a >= 16384) begin
                    m_err = 1'b1;
                end else begin
                    for (int k = 0; k < 16; k++)
                        if (a + k < m_tot)
                            m_bank[m_back][int'(a) + k] = int'(recon_data[8*k +: 8]);
                    if (a != m_last && m_cnt < 65535)
                        m_cnt++;
                    m_last = a;
                end
            end
            if (tile_done && was_fill) begin
                m_ftot  = m_tot;
                m_beats = m_cnt;
                m_fv    = 1'b1;
                m_ready = 1'b1;
                m_back  = 1 - m_back;
                m_fill  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rd_valid", ref_rd_valid, m_rd_vld);
            if (m_rd_dat >= 0)
                chk("rd_data", ref_pixel_data, m_rd_dat);
            chk("frame_ready", frame_ready, m_ready);
            chk("front_valid", front_valid, m_fv);
            chk("frame_beats", frame_beats, m_beats);
            chk("addr_err", addr_err, m_err);
        end
    end

    task automatic cyc(input bit wr, input int addr, input int lane, input bit td, input bit rd, input int raddr);
        logic [7:0] l8;
        l8            = 8'(lane);
        recon_wr_en   = wr;
        recon_addr    = 32'(addr);
        recon_data    = {16{l8}};
        tile_done     = td;
        ref_read_en   = rd;
        ref_read_addr = 32'(raddr);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;
        chk("rst_front_valid", front_valid, 0);
        chk("rst_frame_beats", frame_beats, 0);
        chk("rst_rd_valid", ref_rd_valid, 0);

        // Read before any frame
        cyc(0, 0, 0, 0, 1, 0);
        chk("pre_frame_rd_valid", ref_rd_valid, 1);
        chk("pre_frame_unavail", ref_pixel_data, 128);
        idle();
        chk("rd_valid_drops", ref_rd_valid, 0);

        // 32x32 frame, lanes = beat index
        for (int i = 0; i < 64; i++) cyc(1, i * 16, i, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("f1_ready", frame_ready, 1);
        chk("f1_beats", frame_beats, 64);
        chk("f1_front_valid", front_valid, 1);
        cyc(0, 0, 0, 0, 1, 17);
        chk("f1_ready_one_cycle", frame_ready, 0);
        chk("f1_read17", ref_pixel_data, 1);
        cyc(0, 0, 0, 0, 1, 1024);
        chk("f1_read_oor", ref_pixel_data, 128);

        // Same frame with final beat held 3 cycles
        for (int i = 0; i < 64; i++) cyc(1, i * 16, i, 0, 0, 0);
        cyc(1, 1008, 63, 0, 0, 0);
        cyc(1, 1008, 63, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("f2_beats", frame_beats, 64);
        chk("f2_addr_err", addr_err, 0);
        cyc(0, 0, 0, 0, 1, 1008);
        chk("f2_read1008", ref_pixel_data, 63);

        // Misaligned and out-of-range beats
        cyc(1, 0, 2, 0, 0, 0);
        cyc(1, 8, 8'h77, 0, 0, 0);
        chk("f3_misaligned_err", addr_err, 1);
        cyc(1, 1024, 8'h77, 0, 0, 0);
        chk("f3_oor_err", addr_err, 1);
        for (int i = 1; i < 64; i++) cyc(1, i * 16, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("f3_beats", frame_beats, 64);
        cyc(0, 0, 0, 0, 1, 8);
        chk("f3_read8_untouched", ref_pixel_data, 2);

        // 20x3 frame: partial last beat, beat at 64 out of range
        frame_width  = 16'd20;
        frame_height = 16'd3;
        cyc(1, 0, 4, 0, 0, 0);
        chk("f4_err_cleared", addr_err, 0);
        cyc(1, 16, 4, 0, 0, 0);
        cyc(1, 32, 4, 0, 0, 0);
        cyc(1, 48, 4, 0, 0, 0);
        cyc(1, 64, 4, 0, 0, 0);
        chk("f4_err_64", addr_err, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("f4_beats", frame_beats, 4);
        cyc(0, 0, 0, 0, 1, 59);
        chk("f4_read59", ref_pixel_data, 4);
        cyc(0, 0, 0, 0, 1, 60);
        chk("f4_read60", ref_pixel_data, 128);

        // Ping-pong: frame A = 5, frame B = 9 with reads during fill
        frame_width  = 16'd32;
        frame_height = 16'd32;
        for (int i = 0; i < 64; i++) cyc(1, i * 16, 5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 63; i++) begin
            cyc(1, i * 16, 9, 0, 1, 0);
            chk("pp_fill_read", ref_pixel_data, 5);
        end
        cyc(1, 1008, 9, 1, 1, 0);
        chk("pp_swap_read", ref_pixel_data, 5);
        chk("pp_swap_ready", frame_ready, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("pp_after_swap", ref_pixel_data, 9);
        cyc(0, 0, 0, 0, 1, 1015);
        chk("pp_swap_beat", ref_pixel_data, 9);

        // Reset mid-fill
        for (int i = 0; i < 10; i++) cyc(1, i * 16, 3, 0, 0, 0);
        recon_wr_en = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_front_valid", front_valid, 0);
        chk("rst_mid_beats", frame_beats, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rst_mid_read", ref_pixel_data, 128);
        cyc(0, 0, 0, 1, 0, 0);
        chk("idle_tile_done", frame_ready, 0);
        idle();
        chk("idle_tile_done_late", frame_ready, 0);
        repeat (3) idle();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
